// File: rtl/bram_burst_initiator.sv
// Burst request generator for a BlockRAM responder port: one command expands into
// one request per address, with credit-limited issue and an in-order read-data FIFO.
module bram_burst_initiator #(
  parameter int unsigned Width               = 8,
  parameter int unsigned AddrWidth           = 8,
  parameter int unsigned MaxOutstanding      = 4,
  parameter int unsigned CLog2MaxOutstanding = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [Width+2*AddrWidth+1:0]     cmd,
  input  logic                             cmd_valid,
  output logic                             cmd_bp,
  output logic [Width+AddrWidth:0]         port_req,
  output logic                             port_req_valid,
  input  logic                             port_req_bp,
  input  logic [Width-1:0]                 port_resp,
  input  logic                             port_resp_valid,
  output logic                             port_resp_bp,
  output logic [Width-1:0]                 rd_data,
  output logic                             rd_data_valid,
  input  logic                             rd_data_bp,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned LenW = AddrWidth + 1;
  localparam int unsigned CntW = CLog2MaxOutstanding + 1;
  localparam int unsigned PtrW = CLog2MaxOutstanding;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state, next_state;

  logic                 wr_r;
  logic [AddrWidth-1:0] cur_addr;
  logic [LenW-1:0]      remaining;
  logic [Width-1:0]     fill_r;
  logic [CntW-1:0]      outstanding;
  logic [CntW-1:0]      fifo_count;
  logic [PtrW-1:0]      wr_ptr, rd_ptr;
  logic [Width-1:0]     fifo_mem [MaxOutstanding];

  logic                 cmd_wr;
  logic [AddrWidth-1:0] cmd_addr;
  logic [LenW-1:0]      cmd_len;
  logic [Width-1:0]     cmd_fill;
  logic                 cmd_accept, req_accept, credit, resp_eff, push, pop;

  assign cmd_wr   = cmd[0];
  assign cmd_addr = cmd[AddrWidth:1];
  assign cmd_len  = cmd[2*AddrWidth+1:AddrWidth+1];
  assign cmd_fill = cmd[Width+2*AddrWidth+1:2*AddrWidth+2];

  assign cmd_accept   = (state == IDLE) && cmd_valid;
  assign req_accept   = port_req_valid && !port_req_bp;
  assign credit       = ((CntW+1)'(outstanding) + (CntW+1)'(fifo_count)) < (CntW+1)'(MaxOutstanding);
  // A response with nothing in flight (and no same-cycle request) is ignored.
  assign resp_eff     = port_resp_valid && ((outstanding != '0) || req_accept);
  assign push         = resp_eff && !wr_r;
  assign pop          = rd_data_valid && !rd_data_bp;
  assign port_resp_bp = 1'b0;

  assign rd_data_valid = (fifo_count != '0);
  assign rd_data       = rd_data_valid ? fifo_mem[rd_ptr] : '0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_valid) next_state = (cmd_len == '0) ? DONE : ISSUE;
      ISSUE:   if (req_accept && (remaining == LenW'(1))) next_state = DRAIN;
      DRAIN:   if ((outstanding == '0) && (fifo_count == '0)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from registered state and counters
  always_comb begin
    cmd_bp         = 1'b1;
    busy           = 1'b1;
    done           = 1'b0;
    port_req_valid = 1'b0;
    port_req       = '0;
    case (state)
      IDLE: begin
        cmd_bp = 1'b0;
        busy   = 1'b0;
      end
      ISSUE: begin
        if (credit) begin
          port_req_valid = 1'b1;
          port_req       = {cur_addr, (wr_r ? fill_r : Width'(0)), wr_r};
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Burst bookkeeping, in-flight counter and FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_r        <= 1'b0;
      cur_addr    <= '0;
      remaining   <= '0;
      fill_r      <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (cmd_accept) begin
        wr_r      <= cmd_wr;
        cur_addr  <= cmd_addr;
        remaining <= cmd_len;
        fill_r    <= cmd_fill;
      end
      if (req_accept) begin
        cur_addr  <= cur_addr + AddrWidth'(1);
        remaining <= remaining - LenW'(1);
      end
      if (req_accept && !resp_eff)      outstanding <= outstanding + CntW'(1);
      else if (!req_accept && resp_eff) outstanding <= outstanding - CntW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CntW'(1);
      else if (!push && pop) fifo_count <= fifo_count - CntW'(1);
      if (push) wr_ptr <= (wr_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr + PtrW'(1);
    end
  end

  // FIFO storage; contents are masked by fifo_count so no reset is needed
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= port_resp;
  end

endmodule

// File: tb/tb_bram_burst_initiator.sv
// Testbench for bram_burst_initiator with a zero-latency BlockRAM responder model
// and request / read-data scoreboards.
module tb_bram_burst_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] cmd;
  logic        cmd_valid;
  logic        cmd_bp;
  logic [16:0] port_req;
  logic        port_req_valid;
  logic        port_req_bp;
  logic [7:0]  port_resp;
  logic        port_resp_valid;
  logic        port_resp_bp;
  logic [7:0]  rd_data;
  logic        rd_data_valid;
  logic        rd_data_bp;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int req_seen = 0;
  int rd_seen = 0;
  int done_cnt = 0;
  int last_acc_cyc = 0;
  int done_cyc = 0;
  logic rdv_seen = 1'b0;

  logic [7:0]  ram     [256];
  logic [7:0]  ref_mem [256];
  logic [16:0] req_q [$];
  logic [7:0]  rd_q  [$];

  bram_burst_initiator dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_bp(cmd_bp),
    .port_req(port_req), .port_req_valid(port_req_valid), .port_req_bp(port_req_bp),
    .port_resp(port_resp), .port_resp_valid(port_resp_valid), .port_resp_bp(port_resp_bp),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_bp(rd_data_bp),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Zero-latency BlockRAM port: responds to every transferred request
  assign port_resp_valid = port_req_valid && !port_req_bp;
  assign port_resp       = ram[port_req[16:9]];
  always @(posedge clk) if (port_resp_valid && port_req[0]) ram[port_req[16:9]] <= port_req[8:1];

  // Scoreboard side: compare every transferred request and popped read word
  always @(negedge clk) begin
    logic [16:0] er;
    logic [7:0]  ed;
    if (!reset) begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (rd_data_valid) rdv_seen = 1'b1;
      if (port_req_valid && !port_req_bp) begin
        req_seen++;
        last_acc_cyc = cyc;
        checks++;
        if (req_q.size() == 0) begin
          errors++; $display("FAIL req_unexpected got=%h", port_req);
        end else begin
          er = req_q.pop_front();
          if (port_req !== er) begin errors++; $display("FAIL req_payload got=%h exp=%h", port_req, er); end
        end
      end
      if (rd_data_valid && !rd_data_bp) begin
        rd_seen++;
        checks++;
        if (rd_q.size() == 0) begin
          errors++; $display("FAIL rd_unexpected got=%h", rd_data);
        end else begin
          ed = rd_q.pop_front();
          if (rd_data !== ed) begin errors++; $display("FAIL rd_data got=%h exp=%h", rd_data, ed); end
        end
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [8:0] len,
                          input logic [7:0] fill, output int tacc);
    logic [7:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = addr + 8'(i);
      req_q.push_back({a, (wr ? fill : 8'h00), wr});
      if (wr) ref_mem[a] = fill;
      else    rd_q.push_back(ref_mem[a]);
    end
    @(posedge clk); #1;
    cmd = {fill, len, addr, wr};
    cmd_valid = 1'b1;
    tacc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!cmd_bp) begin tacc = cyc; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (tacc < 0) begin errors++; $display("FAIL cmd_accept got=timeout exp=accepted"); end
  endtask

  task automatic wait_done();
    int seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (seen == 0) begin errors++; $display("FAIL done_timeout got=0 exp=1"); end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd = '0; cmd_valid = 1'b0; port_req_bp = 1'b0; rd_data_bp = 1'b0;
    for (int i = 0; i < 256; i++) begin ram[i] = 8'(i * 7 + 3); ref_mem[i] = 8'(i * 7 + 3); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 8;
    if (port_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", port_req_valid); end
    if (port_req !== 17'h0)      begin errors++; $display("FAIL rst_req got=%h exp=0", port_req); end
    if (rd_data_valid !== 1'b0)  begin errors++; $display("FAIL rst_rd_valid got=%b exp=0", rd_data_valid); end
    if (rd_data !== 8'h00)       begin errors++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
    if (done !== 1'b0)           begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    if (busy !== 1'b0)           begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (cmd_bp !== 1'b0)         begin errors++; $display("FAIL rst_cmd_bp got=%b exp=0", cmd_bp); end
    if (port_resp_bp !== 1'b0)   begin errors++; $display("FAIL rst_resp_bp got=%b exp=0", port_resp_bp); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_write();
    int t, d0;
    rdv_seen = 1'b0;
    d0 = done_cnt;
    send_cmd(1'b1, 8'h10, 9'd4, 8'hA5, t);
    repeat (15) @(posedge clk);
    #1;
    checks += 5;
    if (done_cnt - d0 != 1)           begin errors++; $display("FAIL wr_done_count got=%0d exp=1", done_cnt - d0); end
    if (done_cyc != last_acc_cyc + 2) begin errors++; $display("FAIL wr_done_timing got=%0d exp=%0d", done_cyc, last_acc_cyc + 2); end
    if (rdv_seen !== 1'b0)            begin errors++; $display("FAIL wr_rd_valid got=1 exp=0"); end
    if (req_q.size() != 0)            begin errors++; $display("FAIL wr_req_left got=%0d exp=0", req_q.size()); end
    if (busy !== 1'b0)                begin errors++; $display("FAIL wr_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_read_bp();
    int t, r0, b0, d0;
    send_cmd(1'b1, 8'h14, 9'd2, 8'hA5, t);
    wait_done();
    rd_data_bp = 1'b1;
    r0 = req_seen; b0 = rd_seen; d0 = done_cnt;
    send_cmd(1'b0, 8'h10, 9'd6, 8'h00, t);
    repeat (15) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (req_seen - r0 != 4)       begin errors++; $display("FAIL rd_credit_reqs got=%0d exp=4", req_seen - r0); end
    if (port_req_valid !== 1'b0)  begin errors++; $display("FAIL rd_credit_valid got=%b exp=0", port_req_valid); end
    if (rd_data_valid !== 1'b1)   begin errors++; $display("FAIL rd_fifo_valid got=%b exp=1", rd_data_valid); end
    @(posedge clk); #1;
    rd_data_bp = 1'b0;
    wait_done();
    checks += 4;
    if (rd_seen - b0 != 6)   begin errors++; $display("FAIL rd_beats got=%0d exp=6", rd_seen - b0); end
    if (req_seen - r0 != 6)  begin errors++; $display("FAIL rd_reqs got=%0d exp=6", req_seen - r0); end
    if (rd_q.size() != 0)    begin errors++; $display("FAIL rd_left got=%0d exp=0", rd_q.size()); end
    if (done_cnt - d0 != 1)  begin errors++; $display("FAIL rd_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_wrap();
    int t;
    send_cmd(1'b0, 8'hFE, 9'd4, 8'h00, t);
    wait_done();
    checks += 2;
    if (req_q.size() != 0) begin errors++; $display("FAIL wrap_req_left got=%0d exp=0", req_q.size()); end
    if (rd_q.size() != 0)  begin errors++; $display("FAIL wrap_rd_left got=%0d exp=0", rd_q.size()); end
  endtask

  task automatic test_len0();
    int t, r0;
    r0 = req_seen;
    send_cmd(1'b1, 8'h55, 9'd0, 8'h77, t);
    @(negedge clk);
    checks += 3;
    if (cyc != t + 1)            begin errors++; $display("FAIL len0_cycle got=%0d exp=%0d", cyc, t + 1); end
    if (done !== 1'b1)           begin errors++; $display("FAIL len0_done got=%b exp=1", done); end
    if (port_req_valid !== 1'b0) begin errors++; $display("FAIL len0_req_valid got=%b exp=0", port_req_valid); end
    @(negedge clk);
    checks += 3;
    if (cmd_bp !== 1'b0)   begin errors++; $display("FAIL len0_cmd_bp got=%b exp=0", cmd_bp); end
    if (done !== 1'b0)     begin errors++; $display("FAIL len0_done_clear got=%b exp=0", done); end
    if (req_seen != r0)    begin errors++; $display("FAIL len0_reqs got=%0d exp=0", req_seen - r0); end
  endtask

  task automatic test_bp_toggle();
    int t, r0, d0;
    logic held;
    logic [16:0] prev;
    r0 = req_seen; d0 = done_cnt; held = 1'b0; prev = '0;
    send_cmd(1'b1, 8'h40, 9'd8, 8'h3C, t);
    for (int i = 0; i < 40; i++) begin
      port_req_bp = (i % 2 == 0);
      @(negedge clk);
      if (held) begin
        checks++;
        if (port_req_valid !== 1'b1 || port_req !== prev) begin
          errors++; $display("FAIL bp_stable got=%b/%h exp=1/%h", port_req_valid, port_req, prev);
        end
      end
      held = port_req_valid && port_req_bp;
      prev = port_req;
      @(posedge clk); #1;
    end
    port_req_bp = 1'b0;
    checks += 3;
    if (req_seen - r0 != 8) begin errors++; $display("FAIL bp_reqs got=%0d exp=8", req_seen - r0); end
    if (req_q.size() != 0)  begin errors++; $display("FAIL bp_req_left got=%0d exp=0", req_q.size()); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int t, d0;
    rd_data_bp = 1'b1;
    send_cmd(1'b0, 8'h20, 9'd8, 8'h00, t);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    d0 = done_cnt;
    #1;
    checks += 6;
    if (port_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid got=%b exp=0", port_req_valid); end
    if (port_req !== 17'h0)      begin errors++; $display("FAIL mid_req got=%h exp=0", port_req); end
    if (rd_data_valid !== 1'b0)  begin errors++; $display("FAIL mid_rd_valid got=%b exp=0", rd_data_valid); end
    if (rd_data !== 8'h00)       begin errors++; $display("FAIL mid_rd_data got=%h exp=0", rd_data); end
    if (busy !== 1'b0)           begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (cmd_bp !== 1'b0)         begin errors++; $display("FAIL mid_cmd_bp got=%b exp=0", cmd_bp); end
    req_q.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rd_data_bp = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt - d0); end
    d0 = done_cnt;
    send_cmd(1'b1, 8'h30, 9'd3, 8'h5A, t);
    wait_done();
    send_cmd(1'b0, 8'h30, 9'd3, 8'h00, t);
    wait_done();
    checks += 3;
    if (done_cnt - d0 != 2) begin errors++; $display("FAIL post_done_count got=%0d exp=2", done_cnt - d0); end
    if (req_q.size() != 0)  begin errors++; $display("FAIL post_req_left got=%0d exp=0", req_q.size()); end
    if (rd_q.size() != 0)   begin errors++; $display("FAIL post_rd_left got=%0d exp=0", rd_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_bp();
    test_wrap();
    test_len0();
    test_bp_toggle();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
